// File: rtl/game_pkg.sv
// Shared playfield geometry, contact bit positions and motion state encodings
// for the player datapath.
package game_pkg;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int SPRITE_SZ = 16;

  localparam logic [1:0] COL_FLOOR = 2'd0;
  localparam logic [1:0] COL_CEIL  = 2'd1;
  localparam logic [1:0] COL_LEFT  = 2'd2;
  localparam logic [1:0] COL_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_GROUND = 2'b00,
    ST_RISE   = 2'b01,
    ST_FALL   = 2'b10
  } motion_state_t;

endpackage

// File: rtl/player_motion_ctrl_if.sv
// Bundle between the input/collision front end (master) and the player motion
// controller (slave); the controller returns position, state and facing.
interface player_motion_ctrl_if;

  logic        btn_left;
  logic        btn_right;
  logic        btn_jump;
  logic [3:0]  playerCol;
  logic [19:0] playerPos;
  logic [1:0]  state;
  logic        facing;

  modport master (
    output btn_left, btn_right, btn_jump, playerCol,
    input  playerPos, state, facing
  );

  modport slave (
    input  btn_left, btn_right, btn_jump, playerCol,
    output playerPos, state, facing
  );

endinterface

// File: rtl/axis_step.sv
// One axis of motion: unsigned position plus signed delta, clamped to [0, MAX],
// with flags telling the caller which end of the range the raw sum reached.
module axis_step #(
  parameter int MAX = 624
) (
  input  logic [9:0]        pos,
  input  logic signed [9:0] delta,
  output logic [9:0]        next_pos,
  output logic              hit_min,
  output logic              hit_max
);

  localparam logic signed [10:0] MAX_S = 11'(MAX);

  logic signed [10:0] sum;

  // 11-bit signed sum so a step past either edge is seen instead of wrapping
  always_comb begin
    sum     = $signed({1'b0, pos}) + $signed({delta[9], delta});
    hit_min = (sum <= 11'sd0);
    hit_max = (sum >= MAX_S);
    if (sum < 11'sd0) begin
      next_pos = '0;
    end else if (sum > MAX_S) begin
      next_pos = MAX_S[9:0];
    end else begin
      next_pos = sum[9:0];
    end
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-frame player physics: walk, jump and gravity FSM, velocity saturation and
// clamped position update, one step per sim_clk rising edge.
module player_motion_ctrl
  import game_pkg::*;
#(
  parameter int X_INIT     = 200,
  parameter int Y_INIT     = 300,
  parameter int X_MAX      = SCREEN_W - SPRITE_SZ,
  parameter int Y_MAX      = SCREEN_H - SPRITE_SZ,
  parameter int WALK_SPEED = 2,
  parameter int JUMP_VEL   = 12,
  parameter int GRAVITY    = 1,
  parameter int MAX_SPEED  = 20
) (
  input logic                 sim_clk,
  input logic                 rst,
  player_motion_ctrl_if.slave pif
);

  localparam logic signed [9:0]  WALK_D  = 10'(WALK_SPEED);
  localparam logic signed [9:0]  JUMP_D  = 10'(JUMP_VEL);
  localparam logic signed [10:0] GRAV_S  = 11'(GRAVITY);
  localparam logic signed [10:0] MAX_S   = 11'(MAX_SPEED);
  localparam logic signed [9:0]  MAX_V   = 10'(MAX_SPEED);

  motion_state_t      state_q, state_d;
  logic [9:0]         x_pos, y_pos, x_next, y_next, y_d;
  logic signed [9:0]  vy, vy_d, dx;
  logic signed [10:0] vy_plus;
  logic               facing_q, jump_q, jump_edge;
  logic               floor_hit, ceil_hit;
  logic               y_hit_min, y_hit_max, x_hit_min, x_hit_max;
  logic               unused;

  assign floor_hit = pif.playerCol[COL_FLOOR];
  assign ceil_hit  = pif.playerCol[COL_CEIL];
  assign jump_edge = pif.btn_jump & ~jump_q;
  assign vy_plus   = $signed({vy[9], vy}) + GRAV_S;

  // Horizontal hits are not needed; walls arrive as contact bits instead
  assign unused = x_hit_min ^ x_hit_max;

  always_comb begin
    dx = '0;
    if (pif.btn_right && !pif.btn_left && !pif.playerCol[COL_RIGHT]) begin
      dx = WALK_D;
    end else if (pif.btn_left && !pif.btn_right && !pif.playerCol[COL_LEFT]) begin
      dx = -WALK_D;
    end
  end

  axis_step #(.MAX(X_MAX)) x_axis (
    .pos(x_pos), .delta(dx), .next_pos(x_next),
    .hit_min(x_hit_min), .hit_max(x_hit_max)
  );

  axis_step #(.MAX(Y_MAX)) y_axis (
    .pos(y_pos), .delta(vy), .next_pos(y_next),
    .hit_min(y_hit_min), .hit_max(y_hit_max)
  );

  always_ff @(posedge sim_clk) begin
    if (rst) begin
      state_q <= ST_FALL;
    end else begin
      state_q <= state_d;
    end
  end

  // Floor wins over ceiling while falling; ceiling and the y=0 clamp win over the apex while rising
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_GROUND: begin
        if (jump_edge && !ceil_hit) begin
          state_d = ST_RISE;
        end else if (!floor_hit) begin
          state_d = ST_FALL;
        end
      end
      ST_RISE: begin
        if (ceil_hit || y_hit_min || (vy_plus >= 11'sd0)) begin
          state_d = ST_FALL;
        end
      end
      default: begin
        state_d = (floor_hit || y_hit_max) ? ST_GROUND : ST_FALL;
      end
    endcase
  end

  always_comb begin
    vy_d = vy;
    y_d  = y_pos;
    case (state_q)
      ST_GROUND: begin
        vy_d = (jump_edge && !ceil_hit) ? -JUMP_D : '0;
      end
      ST_RISE: begin
        if (ceil_hit) begin
          vy_d = '0;
        end else begin
          y_d  = y_next;
          vy_d = y_hit_min ? '0 : vy_plus[9:0];
        end
      end
      default: begin
        if (floor_hit) begin
          vy_d = '0;
        end else begin
          y_d  = y_next;
          if (y_hit_max) begin
            vy_d = '0;
          end else begin
            vy_d = (vy_plus > MAX_S) ? MAX_V : vy_plus[9:0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge sim_clk) begin
    if (rst) begin
      x_pos    <= 10'(X_INIT);
      y_pos    <= 10'(Y_INIT);
      vy       <= '0;
      facing_q <= 1'b0;
      jump_q   <= 1'b0;
    end else begin
      x_pos  <= x_next;
      y_pos  <= y_d;
      vy     <= vy_d;
      jump_q <= pif.btn_jump;
      if (dx != '0) begin
        facing_q <= dx[9];
      end
    end
  end

  assign pif.playerPos = {x_pos, y_pos};
  assign pif.state     = state_q;
  assign pif.facing    = facing_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: an integer model of the motion rules
// is compared every frame, with hand-worked positions pinning key moments.
module tb_player_motion_ctrl;

  localparam int MODE_GROUND = 0;
  localparam int MODE_RISE   = 1;
  localparam int MODE_FALL   = 2;

  typedef struct {
    int x;
    int y;
    int vy;
    int mode;
    bit facing;
    bit jprev;
  } model_t;

  logic   sim_clk = 1'b0;
  logic   rst;
  bit     checking = 1'b0;
  int     errors = 0;
  int     checks = 0;
  model_t m;

  player_motion_ctrl_if pif ();

  player_motion_ctrl dut (
    .sim_clk(sim_clk),
    .rst    (rst),
    .pif    (pif)
  );

  always #5 sim_clk = ~sim_clk;

  function automatic int clampi(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // One frame of the game rules, written straight from the motion description
  function automatic model_t model_next(model_t cur, bit l, bit r, bit j, bit [3:0] col);
    model_t nxt = cur;
    int dx = 0;
    int ny = cur.y + cur.vy;
    bit jedge = j && !cur.jprev;
    nxt.jprev = j;
    if (r && !l && !col[3]) dx = 2;
    else if (l && !r && !col[2]) dx = -2;
    if (dx != 0) nxt.facing = (dx < 0);
    nxt.x = clampi(cur.x + dx, 624);
    if (cur.mode == MODE_GROUND) begin
      nxt.vy = 0;
      if (jedge && !col[1]) begin
        nxt.mode = MODE_RISE;
        nxt.vy = -12;
      end else if (!col[0]) begin
        nxt.mode = MODE_FALL;
      end
    end else if (cur.mode == MODE_RISE) begin
      if (col[1]) begin
        nxt.mode = MODE_FALL;
        nxt.vy = 0;
      end else if (ny <= 0) begin
        nxt.y = 0;
        nxt.mode = MODE_FALL;
        nxt.vy = 0;
      end else begin
        nxt.y = ny;
        nxt.vy = cur.vy + 1;
        if (nxt.vy >= 0) nxt.mode = MODE_FALL;
      end
    end else begin
      if (col[0]) begin
        nxt.mode = MODE_GROUND;
        nxt.vy = 0;
      end else if (ny >= 464) begin
        nxt.y = 464;
        nxt.mode = MODE_GROUND;
        nxt.vy = 0;
      end else begin
        nxt.y = ny;
        nxt.vy = (cur.vy + 1 > 20) ? 20 : cur.vy + 1;
      end
    end
    return nxt;
  endfunction

  always @(posedge sim_clk) begin
    if (rst) begin
      m <= '{x: 200, y: 300, vy: 0, mode: MODE_FALL, facing: 1'b0, jprev: 1'b0};
    end else begin
      m <= model_next(m, pif.btn_left, pif.btn_right, pif.btn_jump, pif.playerCol);
    end
  end

  task automatic check_output(string name, int actual, int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge sim_clk) begin
    if (checking) begin
      check_output("model_x", int'(pif.playerPos[19:10]), m.x);
      check_output("model_y", int'(pif.playerPos[9:0]), m.y);
      check_output("model_state", int'(pif.state), m.mode);
      check_output("model_facing", int'(pif.facing), int'(m.facing));
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge sim_clk);
    #2;
  endtask

  task automatic apply_stimulus(bit l, bit r, bit j, bit [3:0] col);
    pif.btn_left  = l;
    pif.btn_right = r;
    pif.btn_jump  = j;
    pif.playerCol = col;
  endtask

  task automatic pulse_jump(bit l, bit r, bit [3:0] col);
    apply_stimulus(l, r, 1'b1, col);
    step(1);
    apply_stimulus(l, r, 1'b0, col);
  endtask

  function automatic int dut_x();
    return int'(pif.playerPos[19:10]);
  endfunction

  function automatic int dut_y();
    return int'(pif.playerPos[9:0]);
  endfunction

  initial begin
    rst = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0001);
    step(1);
    rst = 1'b0;
    checking = 1'b1;
    check_output("reset_state", int'(pif.state), 2);
    check_output("reset_x", dut_x(), 200);
    check_output("reset_y", dut_y(), 300);
    check_output("reset_facing", int'(pif.facing), 0);
    step(1);
    check_output("land_state", int'(pif.state), 0);
    step(3);
    check_output("idle_y", dut_y(), 300);
    check_output("idle_x", dut_x(), 200);

    apply_stimulus(1'b0, 1'b1, 1'b0, 4'b0001);
    step(10);
    check_output("walk_right_x", dut_x(), 220);
    check_output("walk_right_facing", int'(pif.facing), 0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 4'b0001);
    step(5);
    check_output("both_held_x", dut_x(), 220);
    apply_stimulus(1'b1, 1'b0, 1'b0, 4'b0001);
    step(3);
    check_output("walk_left_x", dut_x(), 214);
    check_output("walk_left_facing", int'(pif.facing), 1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0001);

    pulse_jump(1'b0, 1'b0, 4'b0001);
    check_output("jump_state", int'(pif.state), 1);
    check_output("jump_y0", dut_y(), 300);
    step(1);
    check_output("jump_y1", dut_y(), 288);
    step(1);
    check_output("jump_y2", dut_y(), 277);
    step(9);
    check_output("jump_y11", dut_y(), 223);
    check_output("jump_state11", int'(pif.state), 1);
    step(1);
    check_output("apex_y", dut_y(), 222);
    check_output("apex_state", int'(pif.state), 2);
    step(1);
    check_output("land1_state", int'(pif.state), 0);
    check_output("land1_y", dut_y(), 222);

    pulse_jump(1'b0, 1'b0, 4'b0001);
    step(2);
    check_output("ceil_pre_y", dut_y(), 199);
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0011);
    step(1);
    check_output("ceil_state", int'(pif.state), 2);
    check_output("ceil_y_held", dut_y(), 199);
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0001);
    step(1);
    check_output("ceil_land_y", dut_y(), 199);

    pulse_jump(1'b0, 1'b0, 4'b0001);
    step(13);
    check_output("hop_a_y", dut_y(), 121);
    pulse_jump(1'b0, 1'b0, 4'b0001);
    step(13);
    check_output("hop_b_y", dut_y(), 43);
    check_output("hop_b_state", int'(pif.state), 0);

    pulse_jump(1'b0, 1'b0, 4'b0001);
    step(4);
    check_output("top_pre_y", dut_y(), 1);
    step(1);
    check_output("top_clamp_y", dut_y(), 0);
    check_output("top_clamp_state", int'(pif.state), 2);
    step(1);
    check_output("top_land_state", int'(pif.state), 0);

    apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0000);
    step(34);
    check_output("fall_y33", dut_y(), 450);
    check_output("fall_state33", int'(pif.state), 2);
    step(1);
    check_output("fall_floor_y", dut_y(), 464);
    check_output("fall_floor_state", int'(pif.state), 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0001);
    step(1);

    apply_stimulus(1'b1, 1'b0, 1'b0, 4'b0101);
    step(3);
    check_output("left_wall_x", dut_x(), 214);
    apply_stimulus(1'b0, 1'b1, 1'b0, 4'b1001);
    step(3);
    check_output("right_wall_x", dut_x(), 214);
    check_output("wall_facing", int'(pif.facing), 1);

    apply_stimulus(1'b1, 1'b0, 1'b0, 4'b0001);
    step(110);
    check_output("left_clamp_x", dut_x(), 0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 4'b0001);
    step(320);
    check_output("right_clamp_x", dut_x(), 624);
    check_output("right_clamp_facing", int'(pif.facing), 0);

    apply_stimulus(1'b0, 1'b0, 1'b1, 4'b0001);
    step(30);
    check_output("held_jump_y", dut_y(), 386);
    check_output("held_jump_state", int'(pif.state), 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0001);
    step(2);

    pulse_jump(1'b0, 1'b0, 4'b0001);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_output("midjump_rst_x", dut_x(), 200);
    check_output("midjump_rst_y", dut_y(), 300);
    check_output("midjump_rst_state", int'(pif.state), 2);
    step(3);
    check_output("post_rst_state", int'(pif.state), 0);

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
